cfg_reg_bank: RTL



---
 rtl/cfg_reg_pkg.sv | 16 +
 rtl/cfg_sticky_status.sv | 23 ++
 rtl/cfg_reg_bank.sv | 119 +++++++++++
 3 files changed

// File: rtl/cfg_reg_pkg.sv
// Shared address map and reset constants for the configuration register bank.
package cfg_reg_pkg;

  localparam logic [7:0] ADDR_ID       = 8'h00;
  localparam logic [7:0] ADDR_CTRL     = 8'h01;
  localparam logic [7:0] ADDR_CMD      = 8'h02;
  localparam logic [7:0] ADDR_STATUS   = 8'h03;
  localparam logic [7:0] ADDR_LOCK     = 8'h04;
  localparam logic [7:0] ADDR_COMMIT   = 8'h05;
  localparam logic [7:0] ADDR_ERRCNT   = 8'h06;
  localparam logic [7:0] ADDR_CFG_BASE = 8'h10;

  // Config writes start out blocked until the unlock key is written.
  localparam logic LOCK_RST = 1'b1;

endpackage

// File: rtl/cfg_sticky_status.sv
// 16-bit sticky status register: level-high set bits, write-1-to-clear mask,
// set takes priority over clear on the same bit in the same cycle.
module cfg_sticky_status (
  input  logic        CLK,
  input  logic        rst,
  input  logic [15:0] i_set,
  input  logic [15:0] i_clr,
  output logic [15:0] o_status
);

  logic [15:0] r_status;

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_status <= 16'h0000;
    end else begin
      r_status <= (r_status & ~i_clr) | i_set;
    end
  end

  assign o_status = r_status;

endmodule

// File: rtl/cfg_reg_bank.sv
// Configuration/status register bank behind the interface bridge: working and
// committed config words, write lock, command pulses, sticky status, error count.
module cfg_reg_bank
  import cfg_reg_pkg::*;
#(
  parameter int          N_CFG      = 8,
  parameter logic [15:0] CHIP_ID    = 16'h5A01,
  parameter logic [15:0] UNLOCK_KEY = 16'hA5A5
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 reg_ce,
  input  logic                 reg_we,
  input  logic [7:0]           reg_addr_0b,
  input  logic [7:0]           reg_wdata_0b,
  input  logic [7:0]           reg_wdata_1b,
  output logic [7:0]           reg_rdata_0b,
  output logic [7:0]           reg_rdata_1b,
  input  logic [15:0]          sts_set,
  output logic [7:0]           cmd_pulse,
  output logic [15:0]          cfg_ctrl,
  output logic [16*N_CFG-1:0]  cfg_active,
  output logic                 locked
);

  logic [15:0]          w_wdata;
  logic                 w_wr;
  logic                 w_rd;
  logic [7:0]           w_cfg_off;
  logic                 w_cfg_hit;
  logic                 w_mapped;
  logic [15:0]          w_status_clr;
  logic [15:0]          w_status;
  logic [15:0]          w_rd_data;

  logic [15:0]          r_rdata;
  logic [7:0]           r_cmd;
  logic [15:0]          r_ctrl;
  logic [16*N_CFG-1:0]  r_active;
  logic [15:0]          r_work [N_CFG];
  logic                 r_locked;
  logic [7:0]           r_errcnt;

  assign w_wdata   = {reg_wdata_1b, reg_wdata_0b};
  assign w_wr      = reg_ce & reg_we;
  assign w_rd      = reg_ce & ~reg_we;
  assign w_cfg_off = reg_addr_0b - ADDR_CFG_BASE;
  assign w_cfg_hit = (reg_addr_0b >= ADDR_CFG_BASE) && (w_cfg_off < 8'(N_CFG));
  // Working-reg addresses past N_CFG fall into the unmapped (error) space.
  assign w_mapped  = (reg_addr_0b <= ADDR_ERRCNT) || w_cfg_hit;

  assign w_status_clr = (w_wr && reg_addr_0b == ADDR_STATUS) ? w_wdata : 16'h0000;

  cfg_sticky_status u_status (
    .CLK      (CLK),
    .rst      (rst),
    .i_set    (sts_set),
    .i_clr    (w_status_clr),
    .o_status (w_status)
  );

  always_comb begin
    w_rd_data = 16'h0000;
    case (reg_addr_0b)
      ADDR_ID:     w_rd_data = CHIP_ID;
      ADDR_CTRL:   w_rd_data = r_ctrl;
      ADDR_STATUS: w_rd_data = w_status;
      ADDR_LOCK:   w_rd_data = {15'b0, r_locked};
      ADDR_ERRCNT: w_rd_data = {8'h00, r_errcnt};
      default:     w_rd_data = 16'h0000;
    endcase
    for (int i = 0; i < N_CFG; i++) begin
      if (w_cfg_hit && w_cfg_off == 8'(i)) w_rd_data = r_work[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_rdata  <= 16'h0000;
      r_cmd    <= 8'h00;
      r_ctrl   <= 16'h0000;
      r_active <= '0;
      r_locked <= LOCK_RST;
      r_errcnt <= 8'h00;
      for (int i = 0; i < N_CFG; i++) r_work[i] <= 16'h0000;
    end else begin
      r_cmd <= 8'h00;
      if (w_rd) r_rdata <= w_rd_data;
      if (reg_ce && !w_mapped && r_errcnt != 8'hFF) r_errcnt <= r_errcnt + 8'd1;
      if (w_wr) begin
        case (reg_addr_0b)
          ADDR_CTRL:   r_ctrl   <= w_wdata;
          ADDR_CMD:    r_cmd    <= w_wdata[7:0];
          ADDR_LOCK:   r_locked <= (w_wdata != UNLOCK_KEY);
          ADDR_COMMIT: begin
            // Commit ignores the lock so already-staged values can still be applied.
            if (w_wdata[0]) begin
              for (int i = 0; i < N_CFG; i++) r_active[16*i +: 16] <= r_work[i];
            end
          end
          default: ;
        endcase
        if (w_cfg_hit && !r_locked) begin
          for (int i = 0; i < N_CFG; i++) begin
            if (w_cfg_off == 8'(i)) r_work[i] <= w_wdata;
          end
        end
      end
    end
  end

  assign reg_rdata_0b = r_rdata[7:0];
  assign reg_rdata_1b = r_rdata[15:8];
  assign cmd_pulse    = r_cmd;
  assign cfg_ctrl     = r_ctrl;
  assign cfg_active   = r_active;
  assign locked       = r_locked;

endmodule
